// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - RV32I decoder behind a single valid/ready register stage
module instr_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [36:0] instructions,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic        rd_we,
  output logic        illegal,
  output logic [31:0] decoded_count
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  logic [36:0] w_onehot;
  logic [31:0] w_imm;
  logic        w_wb;
  logic        w_illegal;
  logic        w_rd_we;
  logic        w_accept;
  logic        w_xfer;

  logic        r_valid;
  logic [36:0] r_instructions;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [31:0] r_imm, r_pc, r_count;
  logic        r_rd_we, r_illegal;

  assign w_op     = instr_in[6:0];
  assign w_f3     = instr_in[14:12];
  assign w_f7     = instr_in[31:25];
  assign w_imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
  assign w_imm_u  = {instr_in[31:12], 12'h000};
  assign w_imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
  assign w_imm_sh = {27'b0, instr_in[24:20]};

  always_comb begin
    w_onehot = '0;
    w_imm    = '0;
    w_wb     = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_wb = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'd0: w_onehot[0] = 1'b1;
            3'd1: w_onehot[5] = 1'b1;
            3'd2: w_onehot[8] = 1'b1;
            3'd3: w_onehot[9] = 1'b1;
            3'd4: w_onehot[2] = 1'b1;
            3'd5: w_onehot[6] = 1'b1;
            3'd6: w_onehot[3] = 1'b1;
            default: w_onehot[4] = 1'b1;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'd0) w_onehot[1] = 1'b1;
          else if (w_f3 == 3'd5) w_onehot[7] = 1'b1;
        end
      end
      7'b0010011: begin
        w_wb  = 1'b1;
        w_imm = w_imm_i;
        case (w_f3)
          3'd0: w_onehot[10] = 1'b1;
          3'd2: w_onehot[17] = 1'b1;
          3'd3: w_onehot[18] = 1'b1;
          3'd4: w_onehot[11] = 1'b1;
          3'd6: w_onehot[12] = 1'b1;
          3'd7: w_onehot[13] = 1'b1;
          3'd1: begin
            w_imm = w_imm_sh;
            if (w_f7 == 7'b0000000) w_onehot[14] = 1'b1;
          end
          default: begin
            w_imm = w_imm_sh;
            if (w_f7 == 7'b0000000) w_onehot[15] = 1'b1;
            else if (w_f7 == 7'b0100000) w_onehot[16] = 1'b1;
          end
        endcase
      end
      7'b0000011: begin
        w_wb  = 1'b1;
        w_imm = w_imm_i;
        case (w_f3)
          3'd0: w_onehot[19] = 1'b1;
          3'd1: w_onehot[20] = 1'b1;
          3'd2: w_onehot[21] = 1'b1;
          3'd4: w_onehot[22] = 1'b1;
          3'd5: w_onehot[23] = 1'b1;
          default: ;
        endcase
      end
      7'b0100011: begin
        w_imm = w_imm_s;
        case (w_f3)
          3'd0: w_onehot[24] = 1'b1;
          3'd1: w_onehot[25] = 1'b1;
          3'd2: w_onehot[26] = 1'b1;
          default: ;
        endcase
      end
      7'b1100011: begin
        w_imm = w_imm_b;
        case (w_f3)
          3'd0: w_onehot[27] = 1'b1;
          3'd1: w_onehot[28] = 1'b1;
          3'd4: w_onehot[29] = 1'b1;
          3'd5: w_onehot[30] = 1'b1;
          3'd6: w_onehot[31] = 1'b1;
          3'd7: w_onehot[32] = 1'b1;
          default: ;
        endcase
      end
      7'b1101111: begin
        w_wb = 1'b1;
        w_imm = w_imm_j;
        w_onehot[33] = 1'b1;
      end
      7'b1100111: begin
        w_wb = 1'b1;
        w_imm = w_imm_i;
        if (w_f3 == 3'd0) w_onehot[34] = 1'b1;
      end
      7'b0110111: begin
        w_wb = 1'b1;
        w_imm = w_imm_u;
        w_onehot[35] = 1'b1;
      end
      7'b0010111: begin
        w_wb = 1'b1;
        w_imm = w_imm_u;
        w_onehot[36] = 1'b1;
      end
      default: ;
    endcase
    // An empty one-hot vector means nothing matched; scrub the side fields.
    if (w_onehot == '0) begin
      w_imm = '0;
      w_wb  = 1'b0;
    end
  end

  assign w_illegal = (w_onehot == '0);
  assign w_rd_we   = w_wb && (instr_in[11:7] != 5'd0);
  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_instructions <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_imm          <= '0;
      r_pc           <= '0;
      r_rd_we        <= 1'b0;
      r_illegal      <= 1'b0;
      r_count        <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else begin
      if (w_xfer) r_count <= r_count + 32'd1;
      if (w_accept) begin
        r_valid        <= 1'b1;
        r_instructions <= w_onehot;
        r_rs1          <= instr_in[19:15];
        r_rs2          <= instr_in[24:20];
        r_rd           <= instr_in[11:7];
        r_imm          <= w_imm;
        r_pc           <= pc_in;
        r_rd_we        <= w_rd_we;
        r_illegal      <= w_illegal;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_valid;
  assign instructions  = r_instructions;
  assign rs1           = r_rs1;
  assign rs2           = r_rs2;
  assign rd            = r_rd;
  assign imm           = r_imm;
  assign pc_out        = r_pc;
  assign rd_we         = r_rd_we;
  assign illegal       = r_illegal;
  assign decoded_count = r_count;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed bench for instr_decode_stage
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, rd_we, illegal;
  logic [31:0] instr_in, pc_in, imm, pc_out, decoded_count;
  logic [36:0] instructions;
  logic [4:0]  rs1, rs2, rd;
  logic [117:0] w_bundle;
  int tests = 0;
  int fails = 0;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .instructions(instructions), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .pc_out(pc_out), .rd_we(rd_we), .illegal(illegal),
    .decoded_count(decoded_count)
  );

  always #5 clk = ~clk;

  // {instructions, rs1, rs2, rd, imm, pc_out, rd_we, illegal}
  assign w_bundle = {instructions, rs1, rs2, rd, imm, pc_out, rd_we, illegal};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    instr_in = instr;
    pc_in    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (w_bundle !== 118'd0) begin
      fails++; $display("FAIL reset_fields got %h exp %h", w_bundle, 118'd0);
    end
    tests++;
    if (out_valid !== 1'b0 || decoded_count !== 32'd0) begin
      fails++; $display("FAIL reset_valid_count got %b/%h exp 0/0", out_valid, decoded_count);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_r_type;
    logic [117:0] e;
    send(32'h002081B3, 32'h100);
    e = {37'h1, 5'd1, 5'd2, 5'd3, 32'h0, 32'h100, 1'b1, 1'b0};
    tests++;
    if (w_bundle !== e || out_valid !== 1'b1) begin
      fails++; $display("FAIL add got %h v=%b exp %h v=1", w_bundle, out_valid, e);
    end
    tests++;
    if (decoded_count !== 32'd0) begin
      fails++; $display("FAIL add_count got %0d exp 0", decoded_count);
    end
  endtask

  task automatic test_i_type;
    logic [117:0] e;
    send(32'hFFF00293, 32'h104);
    e = {37'h400, 5'd0, 5'd31, 5'd5, 32'hFFFFFFFF, 32'h104, 1'b1, 1'b0};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL addi got %h exp %h", w_bundle, e);
    end
    send(32'h40315113, 32'h108);
    e = {37'h10000, 5'd2, 5'd3, 5'd2, 32'h3, 32'h108, 1'b1, 1'b0};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL srai got %h exp %h", w_bundle, e);
    end
    tests++;
    if (decoded_count !== 32'd2) begin
      fails++; $display("FAIL i_count got %0d exp 2", decoded_count);
    end
  endtask

  task automatic test_upper_jump;
    logic [117:0] e;
    send(32'h123450B7, 32'h10C);
    e = {37'h800000000, 5'd8, 5'd3, 5'd1, 32'h12345000, 32'h10C, 1'b1, 1'b0};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL lui got %h exp %h", w_bundle, e);
    end
    send(32'h001000EF, 32'h110);
    e = {37'h200000000, 5'd0, 5'd1, 5'd1, 32'h800, 32'h110, 1'b1, 1'b0};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL jal got %h exp %h", w_bundle, e);
    end
  endtask

  task automatic test_mem_branch;
    logic [117:0] e;
    send(32'h0020A423, 32'h114);
    e = {37'h4000000, 5'd1, 5'd2, 5'd8, 32'h8, 32'h114, 1'b0, 1'b0};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL sw got %h exp %h", w_bundle, e);
    end
    send(32'hFE000EE3, 32'h118);
    e = {37'h8000000, 5'd0, 5'd0, 5'd29, 32'hFFFFFFFC, 32'h118, 1'b0, 1'b0};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL beq got %h exp %h", w_bundle, e);
    end
  endtask

  task automatic test_illegal;
    logic [117:0] e;
    send(32'h00000000, 32'h11C);
    e = {37'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h11C, 1'b0, 1'b1};
    tests++;
    if (w_bundle !== e || out_valid !== 1'b1) begin
      fails++; $display("FAIL zero_word got %h v=%b exp %h v=1", w_bundle, out_valid, e);
    end
    send(32'h02009093, 32'h120);
    e = {37'h0, 5'd1, 5'd0, 5'd1, 32'h0, 32'h120, 1'b0, 1'b1};
    tests++;
    if (w_bundle !== e) begin
      fails++; $display("FAIL slli_bit25 got %h exp %h", w_bundle, e);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || decoded_count !== 32'd9) begin
      fails++; $display("FAIL drain got v=%b cnt=%0d exp v=0 cnt=9", out_valid, decoded_count);
    end
  endtask

  task automatic test_backpressure;
    logic [117:0] ea, eb, ec;
    ea = {37'h1, 5'd1, 5'd2, 5'd3, 32'h0, 32'h200, 1'b1, 1'b0};
    eb = {37'h400, 5'd0, 5'd31, 5'd5, 32'hFFFFFFFF, 32'h204, 1'b1, 1'b0};
    ec = {37'h800000000, 5'd8, 5'd3, 5'd1, 32'h12345000, 32'h208, 1'b1, 1'b0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'h002081B3;
    pc_in     = 32'h200;
    tick();
    instr_in = 32'hFFF00293;
    pc_in    = 32'h204;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (w_bundle !== ea || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stall%0d got %h v=%b rdy=%b exp %h v=1 rdy=0", i, w_bundle, out_valid, in_ready, ea);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL release_ready got %b exp 1", in_ready);
    end
    tick();
    tests++;
    if (w_bundle !== eb || out_valid !== 1'b1 || decoded_count !== 32'd10) begin
      fails++; $display("FAIL bp_b got %h cnt=%0d exp %h cnt=10", w_bundle, decoded_count, eb);
    end
    instr_in = 32'h123450B7;
    pc_in    = 32'h208;
    tick();
    tests++;
    if (w_bundle !== ec || out_valid !== 1'b1 || decoded_count !== 32'd11) begin
      fails++; $display("FAIL bp_c got %h cnt=%0d exp %h cnt=11", w_bundle, decoded_count, ec);
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || decoded_count !== 32'd12) begin
      fails++; $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=12", out_valid, decoded_count);
    end
  endtask

  task automatic test_flush;
    send(32'h002081B3, 32'h300);
    tests++;
    if (out_valid !== 1'b1 || decoded_count !== 32'd12) begin
      fails++; $display("FAIL pre_flush got v=%b cnt=%0d exp v=1 cnt=12", out_valid, decoded_count);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    instr_in = 32'hFFF00293;
    pc_in    = 32'h304;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || decoded_count !== 32'd12) begin
      fails++; $display("FAIL flush got v=%b cnt=%0d exp v=0 cnt=12", out_valid, decoded_count);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || decoded_count !== 32'd12) begin
      fails++; $display("FAIL flush_after got v=%b cnt=%0d exp v=0 cnt=12", out_valid, decoded_count);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(32'h002081B3, 32'h400);
    tests++;
    if (out_valid !== 1'b1 || pc_out !== 32'h400) begin
      fails++; $display("FAIL pre_rst got v=%b pc=%h exp v=1 pc=400", out_valid, pc_out);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (w_bundle !== 118'd0 || out_valid !== 1'b0 || decoded_count !== 32'd0) begin
      fails++; $display("FAIL mid_rst got %h v=%b cnt=%0d exp 0", w_bundle, out_valid, decoded_count);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL post_rst got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr_in  = 32'h0;
    pc_in     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_r_type();
    test_i_type();
    test_upper_jump();
    test_mem_branch();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 in_valid  input  1  instr_in and pc_in are valid this cycle.
REQ-004 in_ready  output  1  the stage accepts a transfer this cycle.
REQ-005 instr_in  input  32  raw RV32I instruction word.
REQ-006 pc_in  input  32  address of instr_in.
REQ-007 flush  input  1  discards the held and incoming decode.
REQ-008 out_valid  output  1  decoded bundle is valid.
REQ-009 out_ready  input  1  downstream accepts the bundle this cycle.
REQ-010 instructions  output  37  one-hot operation vector, the ALU control encoding.
REQ-011 rs1, rs2, rd  output  5 each  register indices, taken from instr[19:15], instr[24:20] and instr[11:7].
REQ-012 imm  output  32  sign-extended immediate.
REQ-013 pc_out  output  32  registered pc_in.
REQ-014 rd_we  output  1  write-back enable.
REQ-015 illegal  output  1  the instruction did not decode.
REQ-016 decoded_count  output  32  number of bundles transferred downstream.

Function
REQ-017 One-hot bit map: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
REQ-018 Bits 10-18: addi, xori, ori, andi, slli, srli, srai, slti, sltiu.
REQ-019 Bits 19-23: lb, lh, lw, lbu, lhu. Bits 24-26: sb, sh, sw.
REQ-020 Bits 27-32: beq, bne, blt, bge, bltu, bgeu. Bits 33-36: jal, jalr, lui, auipc.
REQ-021 Exactly one bit of instructions is set for a legal decode.
REQ-022 Decoding uses opcode, funct3 and funct7 per RV32I.
REQ-023 Immediate formats:
- I: instr[31:20] sign-extended.
- S: {instr[31:25], instr[11:7]} sign-extended.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
- U: {instr[31:12], 12'h000}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
- R-type: 0.
- Shift-immediate: imm = {27'b0, instr[24:20]}.
REQ-024 Any of the following sets illegal=1, instructions=0 and rd_we=0:
- unknown opcode;
- unknown funct3/funct7 combination;
- slli, srli or srai with instr[25]=1.
REQ-025 rd_we=1 only for R, I-ALU, load, jal, jalr, lui and auipc, and only when rd!=0.
REQ-026 Single register stage. in_ready = !out_valid || out_ready, combinational.
REQ-027 Accept on in_valid && in_ready: all output fields load the next cycle and out_valid=1.
REQ-028 While out_valid && !out_ready, every output field holds stable.
REQ-029 Output transfer occurs on out_valid && out_ready: decoded_count increments by 1 and wraps from 0xFFFFFFFF to 0.
REQ-030 Simultaneous transfer-out and accept: new bundle loads, out_valid stays 1, no bubble.
REQ-031 flush=1: out_valid=0 next cycle and any same-cycle accept is dropped.
REQ-032 A bundle cleared by flush is not counted, even if out_ready=1 in the flush cycle.
REQ-033 flush has priority over accept and transfer; rst has priority over flush.
REQ-034 Latency: exactly 1 cycle from accept to out_valid.

Reset
REQ-035 On rst: out_valid=0, instructions=0, rs1=rs2=rd=0, imm=0, pc_out=0, rd_we=0, illegal=0, decoded_count=0.
REQ-036 Reset mid-operation discards the held bundle. in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-037 instr_in=0x002081B3 (add x3,x1,x2) -> next cycle: instructions=37'h1, rs1=1, rs2=2, rd=3, rd_we=1, imm=0.
REQ-038 Two scenarios:
- 0xFFF00293 (addi x5,x0,-1) -> instructions=37'h400, imm=0xFFFFFFFF, rd=5.
- 0x40315113 (srai x2,x2,3) -> instructions=37'h10000, imm=3.
REQ-039 0x123450B7 (lui x1,0x12345) -> instructions=37'h800000000, imm=0x12345000, rd_we=1.
REQ-040 instr_in=0x00000000 -> illegal=1, instructions=0, rd_we=0, out_valid=1.
REQ-041 Backpressure case:
- Stimulus: out_ready=0 for 3 cycles after an accept, with in_valid held 1.
- Response: outputs stable and in_ready=0 for those cycles.
- Then out_ready=1: one transfer per cycle and decoded_count advances by 1 per transfer.
REQ-042 flush asserted together with in_valid=1 and out_ready=1 -> out_valid=0 next cycle, decoded_count unchanged.
REQ-043 rst asserted while out_valid=1 -> all outputs at reset values next cycle.
